// File: rtl/sky130_fd_io__hvc_pwrgood_seq.sv
// Pad-supply power-good sequencer: synchronizes VDET, debounces it, dwells in SETTLE, then releases IO hold.
// Optional glitch/brown-out event counter enabled by defining SKY130_FD_IO_PWRGOOD_GLITCH_CNT_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   OFF      | sequencer idle, all outputs low
//   DEBOUNCE | vdet_s high, counting DEB_CYCLES before trusting it
//   SETTLE   | HV domain enabled, waiting HOLD_CYCLES before release
//   GOOD     | supply good, IO hold released
//   FAULT    | brown-out seen; sticky until ENABLE drops
module sky130_fd_io__hvc_pwrgood_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 16,
   parameter int HOLD_CYCLES = 8,
   parameter int CNT_W       = 8
) (
   input  logic       CLK,
   input  logic       RESET_B,
   input  logic       ENABLE,
   input  logic       VDET,
   output logic       ENABLE_H,
   output logic       HLD_H_N,
   output logic       PWR_GOOD,
   output logic       FAULT,
   output logic [2:0] STATE,
   output logic [7:0] GLITCH_CNT
);

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_GOOD     = 3'd3,
      ST_FAULT    = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   vdet_s;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   enable_h_q, hld_h_n_q, pwr_good_q, fault_q;

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], VDET};
   end

   assign vdet_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!ENABLE) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (vdet_s) begin
                  state_d = ST_DEBOUNCE;
                  cnt_d   = '0;
               end
            end
            ST_DEBOUNCE: begin
               if (!vdet_s) begin
                  state_d = ST_OFF;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = ST_SETTLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_SETTLE: begin
               if (!vdet_s) begin
                  state_d = ST_FAULT;
                  cnt_d   = '0;
               end else if (cnt_q == HOLD_LAST) begin
                  state_d = ST_GOOD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_GOOD: begin
               if (!vdet_s) state_d = ST_FAULT;
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from state_d and registered, so they line up with state_q.
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         state_q    <= ST_OFF;
         cnt_q      <= '0;
         enable_h_q <= 1'b0;
         hld_h_n_q  <= 1'b0;
         pwr_good_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         enable_h_q <= (state_d == ST_SETTLE) || (state_d == ST_GOOD);
         hld_h_n_q  <= (state_d == ST_GOOD);
         pwr_good_q <= (state_d == ST_GOOD);
         fault_q    <= (state_d == ST_FAULT);
      end
   end

   assign ENABLE_H = enable_h_q;
   assign HLD_H_N  = hld_h_n_q;
   assign PWR_GOOD = pwr_good_q;
   assign FAULT    = fault_q;
   assign STATE    = state_q;

`ifdef SKY130_FD_IO_PWRGOOD_GLITCH_CNT_EN
   logic [7:0] glitch_q;
   logic       glitch_evt;

   assign glitch_evt = ENABLE &&
                       (((state_q == ST_DEBOUNCE) && !vdet_s) ||
                        ((state_d == ST_FAULT) && (state_q != ST_FAULT)));

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B)                             glitch_q <= 8'd0;
      else if (glitch_evt && glitch_q != 8'hFF) glitch_q <= glitch_q + 8'd1;
   end

   assign GLITCH_CNT = glitch_q;
`else
   assign GLITCH_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_sky130_fd_io__hvc_pwrgood_seq.sv
// Directed bench for the power-good sequencer; builds with or without the glitch counter macro.
module tb_sky130_fd_io__hvc_pwrgood_seq;

`ifdef SKY130_FD_IO_PWRGOOD_GLITCH_CNT_EN
   localparam bit GC_EN = 1'b1;
`else
   localparam bit GC_EN = 1'b0;
`endif

   // {ENABLE_H, HLD_H_N, PWR_GOOD, FAULT, STATE}
   localparam logic [6:0] O_OFF    = 7'b0000_000;
   localparam logic [6:0] O_DEB    = 7'b0000_001;
   localparam logic [6:0] O_SETTLE = 7'b1000_010;
   localparam logic [6:0] O_GOOD   = 7'b1110_011;
   localparam logic [6:0] O_FAULT  = 7'b0001_100;

   logic       CLK = 1'b0;
   logic       RESET_B = 1'b0;
   logic       ENABLE = 1'b0;
   logic       VDET = 1'b0;
   logic       ENABLE_H, HLD_H_N, PWR_GOOD, FAULT;
   logic [2:0] STATE;
   logic [7:0] GLITCH_CNT;

   int n_pass  = 0;
   int n_total = 0;

   sky130_fd_io__hvc_pwrgood_seq dut (
      .CLK       (CLK),
      .RESET_B   (RESET_B),
      .ENABLE    (ENABLE),
      .VDET      (VDET),
      .ENABLE_H  (ENABLE_H),
      .HLD_H_N   (HLD_H_N),
      .PWR_GOOD  (PWR_GOOD),
      .FAULT     (FAULT),
      .STATE     (STATE),
      .GLITCH_CNT(GLITCH_CNT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [6:0] outs();
      return {ENABLE_H, HLD_H_N, PWR_GOOD, FAULT, STATE};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset();
      RESET_B = 1'b0;
      ENABLE  = 1'b1;
      VDET    = 1'b1;
      tick(3);
      n_total++;
      if (outs() !== O_OFF) $display("FAIL reset_outs: got %b expected %b", outs(), O_OFF);
      else n_pass++;
      n_total++;
      if (GLITCH_CNT !== 8'd0) $display("FAIL reset_glitch: got %0d expected 0", GLITCH_CNT);
      else n_pass++;
      ENABLE  = 1'b0;
      VDET    = 1'b0;
      RESET_B = 1'b1;
      tick(1);
      n_total++;
      if (outs() !== O_OFF) $display("FAIL post_reset_off: got %b expected %b", outs(), O_OFF);
      else n_pass++;
   endtask

   task automatic test_powerup();
      ENABLE = 1'b1;
      tick(2);
      n_total++;
      if (outs() !== O_OFF) $display("FAIL pu_idle: got %b expected %b", outs(), O_OFF);
      else n_pass++;
      VDET = 1'b1;
      tick(18);
      n_total++;
      if (outs() !== O_DEB) $display("FAIL pu_edge18: got %b expected %b", outs(), O_DEB);
      else n_pass++;
      tick(1);
      n_total++;
      if (outs() !== O_SETTLE) $display("FAIL pu_edge19: got %b expected %b", outs(), O_SETTLE);
      else n_pass++;
      tick(7);
      n_total++;
      if (outs() !== O_SETTLE) $display("FAIL pu_edge26: got %b expected %b", outs(), O_SETTLE);
      else n_pass++;
      tick(1);
      n_total++;
      if (outs() !== O_GOOD) $display("FAIL pu_edge27: got %b expected %b", outs(), O_GOOD);
      else n_pass++;
   endtask

   task automatic test_debounce_abort();
      int pg_seen;
      ENABLE = 1'b0;
      VDET   = 1'b0;
      tick(3);
      n_total++;
      if (outs() !== O_OFF) $display("FAIL da_disable: got %b expected %b", outs(), O_OFF);
      else n_pass++;
      ENABLE = 1'b1;
      tick(2);
      VDET = 1'b1;
      tick(10);
      n_total++;
      if (outs() !== O_DEB) $display("FAIL da_debounce: got %b expected %b", outs(), O_DEB);
      else n_pass++;
      VDET = 1'b0;
      tick(2);
      n_total++;
      if (outs() !== O_DEB) $display("FAIL da_still_deb: got %b expected %b", outs(), O_DEB);
      else n_pass++;
      tick(1);
      n_total++;
      if (outs() !== O_OFF) $display("FAIL da_abort: got %b expected %b", outs(), O_OFF);
      else n_pass++;
      n_total++;
      if (GLITCH_CNT !== (GC_EN ? 8'd1 : 8'd0))
         $display("FAIL da_glitch: got %0d expected %0d", GLITCH_CNT, GC_EN ? 1 : 0);
      else n_pass++;
      pg_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (PWR_GOOD !== 1'b0 || STATE !== 3'd0) pg_seen++;
      end
      n_total++;
      if (pg_seen != 0) $display("FAIL da_stays_off: got %0d bad cycles expected 0", pg_seen);
      else n_pass++;
   endtask

   task automatic test_brownout();
      VDET = 1'b1;
      tick(27);
      n_total++;
      if (outs() !== O_GOOD) $display("FAIL bo_good: got %b expected %b", outs(), O_GOOD);
      else n_pass++;
      VDET = 1'b0;
      tick(1);
      VDET = 1'b1;
      tick(1);
      n_total++;
      if (outs() !== O_GOOD) $display("FAIL bo_edge2: got %b expected %b", outs(), O_GOOD);
      else n_pass++;
      tick(1);
      n_total++;
      if (outs() !== O_FAULT) $display("FAIL bo_edge3: got %b expected %b", outs(), O_FAULT);
      else n_pass++;
      tick(5);
      n_total++;
      if (outs() !== O_FAULT) $display("FAIL bo_sticky: got %b expected %b", outs(), O_FAULT);
      else n_pass++;
      n_total++;
      if (GLITCH_CNT !== (GC_EN ? 8'd2 : 8'd0))
         $display("FAIL bo_glitch: got %0d expected %0d", GLITCH_CNT, GC_EN ? 2 : 0);
      else n_pass++;
      ENABLE = 1'b0;
      tick(1);
      n_total++;
      if (outs() !== O_OFF) $display("FAIL bo_disable: got %b expected %b", outs(), O_OFF);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      ENABLE = 1'b1;
      tick(20);
      n_total++;
      if (outs() !== O_SETTLE) $display("FAIL rm_settle: got %b expected %b", outs(), O_SETTLE);
      else n_pass++;
      #3;
      RESET_B = 1'b0;
      #1;
      n_total++;
      if (outs() !== O_OFF) $display("FAIL rm_async: got %b expected %b", outs(), O_OFF);
      else n_pass++;
      n_total++;
      if (GLITCH_CNT !== 8'd0) $display("FAIL rm_glitch: got %0d expected 0", GLITCH_CNT);
      else n_pass++;
      #1;
      RESET_B = 1'b1;
      tick(26);
      n_total++;
      if (outs() !== O_SETTLE) $display("FAIL rm_edge26: got %b expected %b", outs(), O_SETTLE);
      else n_pass++;
      tick(1);
      n_total++;
      if (outs() !== O_GOOD) $display("FAIL rm_edge27: got %b expected %b", outs(), O_GOOD);
      else n_pass++;
   endtask

   task automatic test_enable_off_good();
      ENABLE = 1'b0;
      tick(1);
      n_total++;
      if (outs() !== O_OFF) $display("FAIL eo_off: got %b expected %b", outs(), O_OFF);
      else n_pass++;
   endtask

   task automatic test_glitch_sat();
      for (int i = 0; i < 300; i++) begin
         ENABLE = 1'b0;
         VDET   = 1'b1;
         tick(3);
         ENABLE = 1'b1;
         tick(25);
         VDET = 1'b0;
         tick(3);
         if (i == 253) begin
            n_total++;
            if (GLITCH_CNT !== (GC_EN ? 8'd254 : 8'd0))
               $display("FAIL gs_254: got %0d expected %0d", GLITCH_CNT, GC_EN ? 254 : 0);
            else n_pass++;
         end
      end
      n_total++;
      if (outs() !== O_FAULT) $display("FAIL gs_fault: got %b expected %b", outs(), O_FAULT);
      else n_pass++;
      n_total++;
      if (GLITCH_CNT !== (GC_EN ? 8'd255 : 8'd0))
         $display("FAIL gs_sat: got %0d expected %0d", GLITCH_CNT, GC_EN ? 255 : 0);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_debounce_abort();
      test_brownout();
      test_reset_mid();
      test_enable_off_good();
      test_glitch_sat();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
